// File: rtl/approx_mult_seq_if.sv
// Handshake and operand bundle for approx_mult_seq: input side (a, b, keep),
// output side (o) and the busy status flag.
interface approx_mult_seq_if #(
  parameter int WIDTH = 12,
  parameter int KW    = $clog2(WIDTH + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [KW-1:0]      keep;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] o;
  logic               busy;

  modport master (
    output in_valid, a, b, keep, out_ready,
    input  in_ready, out_valid, o, busy
  );

  modport slave (
    input  in_valid, a, b, keep, out_ready,
    output in_ready, out_valid, o, busy
  );
endinterface

// File: rtl/approx_mult_seq.sv
// Approximate unsigned multiplier: operands truncated to their KEEP MSBs, product
// built by an MSB-first shift-add loop. Define APPROX_MULT_ROUND_EN for midpoint bias compensation.
module approx_mult_seq #(
  parameter int WIDTH = 12,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  approx_mult_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic [KW-1:0]      sh_q, sh_d;
  logic [2*WIDTH-1:0] o_q, o_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic [KW-1:0]      k_s;
  logic [KW-1:0]      t_s;
  logic [WIDTH-1:0]   mask_s;
  logic [WIDTH-1:0]   a_tr_s;
  logic [WIDTH-1:0]   b_tr_s;

  // t_s is the number of discarded low bits; the loop scans WIDTH-t_s bits of B'.
  always_comb begin
    if ((bus.keep == {KW{1'b0}}) || (bus.keep > KW'(WIDTH))) begin
      k_s = KW'(WIDTH);
    end else begin
      k_s = bus.keep;
    end
    t_s    = KW'(WIDTH) - k_s;
    mask_s = {WIDTH{1'b1}} << t_s;
    a_tr_s = bus.a & mask_s;
    b_tr_s = bus.b & mask_s;
`ifdef APPROX_MULT_ROUND_EN
    if (t_s != {KW{1'b0}}) begin
      t_s    = t_s - KW'(1);
      a_tr_s = a_tr_s | (WIDTH'(1) << t_s);
      b_tr_s = b_tr_s | (WIDTH'(1) << t_s);
    end else begin
      t_s    = t_s;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_BUSY;
          acc_d   = {(2*WIDTH){1'b0}};
          a_d     = a_tr_s >> t_s;
          b_d     = b_tr_s;
          cnt_d   = KW'(WIDTH) - t_s;
          sh_d    = t_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
              + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : {(2*WIDTH){1'b0}});
        b_d   = {b_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          state_d = S_DONE;
          o_d     = acc_d << {sh_q, 1'b0};
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          o_d     = {(2*WIDTH){1'b0}};
          acc_d   = {(2*WIDTH){1'b0}};
          a_d     = {WIDTH{1'b0}};
          b_d     = {WIDTH{1'b0}};
          cnt_d   = {KW{1'b0}};
          sh_d    = {KW{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        o_d     = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // Handshake flags are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= {(2*WIDTH){1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cnt_q       <= {KW{1'b0}};
      sh_q        <= {KW{1'b0}};
      o_q         <= {(2*WIDTH){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      o_q         <= o_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d == S_BUSY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.o         = o_q;

endmodule

// File: doc/approx_mult_seq.md
Name: approx_mult_seq

Overview:
- Parametrised, runtime-configurable approximate multiplier for the configurable hardware experiments.
- Each operand is truncated to its KEEP most-significant bits. The product of the truncated operands is formed by an iterative MSB-first shift-add datapath.
- Latency scales with KEEP, trading accuracy for cycles and energy.
- Valid/ready handshakes on both the input and output sides allow drop-in use in streaming testbenches and accelerator datapaths.

Parameters:
- WIDTH, 12, operand width in bits; product is 2*WIDTH bits.
- KW, $clog2(WIDTH+1), width of the keep configuration port (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and keep are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  unsigned multiplicand.
- b  input  WIDTH  unsigned multiplier.
- keep  input  KW  number of MSBs retained per operand.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- o  output  2*WIDTH  approximate unsigned product.
- busy  output  1  high while iterating.

Behaviour:
- Reset: async, active-high.
  - State returns to IDLE; accumulator and all operand registers clear.
  - Output values: in_ready=1, out_valid=0, busy=0, o=0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. Accept on an edge with in_valid&&in_ready; go to BUSY.
  - BUSY: busy=1, in_ready=0. Perform one iteration per cycle. After the last iteration go to DONE.
  - DONE: out_valid=1, in_ready=0. On an edge with out_ready high go to IDLE.
- Configuration capture: keep is sampled only at accept. keep==0 or keep>WIDTH is clamped to k=WIDTH (exact mode). Otherwise k=keep.
- Truncation:
  - A' = a with its low (WIDTH-k) bits zeroed; B' likewise from b.
  - Result o = A'*B', exact 2*WIDTH-bit unsigned, no overflow possible.
- Iteration:
  - acc starts at 0. For i = WIDTH-1 down to WIDTH-k: acc = (acc<<1) + (B'[i] ? (A'>>(WIDTH-k)) : 0).
  - The final value is shifted left by 2*(WIDTH-k) when loaded into o.
  - The implementation may realise this differently, but the cycle count and result are fixed.
- Latency:
  - Exactly k BUSY cycles. out_valid rises after the k-th iteration edge, i.e. k cycles after the accept edge.
  - The minimum accept-to-accept interval is k+2 cycles when out_ready is held high.
- Output hold: o and out_valid are held stable while out_valid && !out_ready.
- No overlap: a new input is never accepted in BUSY or DONE. in_valid asserted in those states is ignored, and the producer must hold it.
- o is registered and is cleared to 0 on return to IDLE.

Optional Feature:
- Macro APPROX_MULT_ROUND_EN enables bias compensation.
- When defined and k<WIDTH:
  - A' and B' additionally set bit (WIDTH-k-1), the midpoint of the truncated range.
  - The iteration covers k+1 bits of B'. BUSY lasts k+1 cycles.
- When k==WIDTH, or when the macro is undefined, behaviour is exactly as above with k cycles.

Test Plan:
- keep=12, a=1234, b=567, out_ready=1 -> o=699678; out_valid exactly 12 cycles after accept; back in IDLE the next cycle.
- keep=1, a=12'hFFF, b=12'hFFF -> o=4194304 (2048*2048); latency 1 cycle. keep=0 with the same operands -> clamped to exact, o=16769025, latency 12.
- keep=4, a=12'hABC, b=12'h9FF -> o=5898240 (2560*2304), latency 4. With APPROX_MULT_ROUND_EN -> o=6537216 (2688*2432), latency 5.
- Backpressure: complete the keep=4 operation with out_ready=0 for 5 cycles -> o and out_valid stable, in_ready=0, a new in_valid pulse is ignored; raise out_ready -> one handshake, then IDLE with in_ready=1.
- Reset mid-op: keep=12, assert rst during the 6th BUSY cycle -> immediately busy=0, out_valid=0, o=0; after release in_ready=1 and the next operation (a=3, b=5, keep=12) yields o=15.
